ctrl_pipe_chain: RTL and testbench

CTRL_PIPE_CHAIN -- requirements
Module: ctrl_pipe_chain

---
 rtl/ctrl_pipe_chain.sv | 101 ++++++++++
 tb/tb_ctrl_pipe_chain.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_chain.sv
// Chain of control-word pipeline registers with per-stage stall, flush and exception kill mask.
// Also keeps a saturating count of bubbles retired and a sticky flag for illegal stall patterns.
module ctrl_pipe_chain #(
    parameter int               WIDTH     = 32,
    parameter int               STAGES    = 3,
    parameter logic [WIDTH-1:0] KILL_MASK = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    input  logic [STAGES-1:0]         except,
    output logic [STAGES*WIDTH-1:0]   stage_data,
    output logic [STAGES-1:0]         stage_valid,
    output logic [15:0]               bub_cnt,
    output logic                      stall_err
);

    logic [WIDTH-1:0]  data_q  [STAGES];
    logic [WIDTH-1:0]  data_d  [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [15:0]       bub_cnt_q;
    logic              stall_err_q;
    logic              stall_err_set;

    // Every stage decides from pre-edge state only, so words advancing in
    // neighbouring stages in the same cycle are never lost.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        for (int i = 0; i < STAGES; i++) begin
            int prev;
            prev = (i > 0) ? i - 1 : 0;
            if (flush[i]) begin
                data_d[i]  = '0;
                valid_d[i] = 1'b0;
            end else if (stall[i]) begin
                data_d[i]  = data_q[i];
                valid_d[i] = valid_q[i];
            end else if (i == 0) begin
                data_d[i]  = in_valid ? in_data : '0;
                valid_d[i] = in_valid;
            end else if (stall[prev]) begin
                // Upstream is holding its word; inject a bubble so it is not duplicated.
                data_d[i]  = '0;
                valid_d[i] = 1'b0;
            end else begin
                data_d[i]  = data_q[prev];
                valid_d[i] = valid_q[prev];
            end
        end
    end

    // A stage stalled while its feeder keeps moving would overwrite the feeder's word.
    always_comb begin
        stall_err_set = 1'b0;
        for (int i = 1; i < STAGES; i++) begin
            if (stall[i] && !stall[i-1] && !flush[i-1]) begin
                stall_err_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
            valid_q     <= '0;
            bub_cnt_q   <= '0;
            stall_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
            valid_q <= valid_d;
            if (!stall[STAGES-1] && !valid_q[STAGES-1] && (bub_cnt_q != 16'hFFFF)) begin
                bub_cnt_q <= bub_cnt_q + 16'd1;
            end
            if (stall_err_set) begin
                stall_err_q <= 1'b1;
            end
        end
    end

    // Kill mask only affects what is shown; the stored word travels on intact.
    always_comb begin
        stage_data = '0;
        for (int i = 0; i < STAGES; i++) begin
            stage_data[i*WIDTH +: WIDTH] = except[i] ? (data_q[i] & ~KILL_MASK) : data_q[i];
        end
    end

    assign stage_valid = valid_q;
    assign bub_cnt     = bub_cnt_q;
    assign stall_err   = stall_err_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Self-checking bench for ctrl_pipe_chain (STAGES=3, WIDTH=8, KILL_MASK=8'h0F).
// Flow-through words are tracked by a scoreboard queue; other behaviours use directed checks.
module tb_ctrl_pipe_chain;

    localparam int         WIDTH  = 8;
    localparam int         STAGES = 3;
    localparam logic [7:0] KMASK  = 8'h0F;

    logic                    clk;
    logic                    rst;
    logic [WIDTH-1:0]        in_data;
    logic                    in_valid;
    logic [STAGES-1:0]       stall;
    logic [STAGES-1:0]       flush;
    logic [STAGES-1:0]       except;
    logic [STAGES*WIDTH-1:0] stage_data;
    logic [STAGES-1:0]       stage_valid;
    logic [15:0]             bub_cnt;
    logic                    stall_err;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    bit   sb_en;
    int   cyc;
    int   n_checks;
    int   n_fail;

    ctrl_pipe_chain #(
        .WIDTH     (WIDTH),
        .STAGES    (STAGES),
        .KILL_MASK (KMASK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .stall       (stall),
        .flush       (flush),
        .except      (except),
        .stage_data  (stage_data),
        .stage_valid (stage_valid),
        .bub_cnt     (bub_cnt),
        .stall_err   (stall_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit later, away from the edge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb_en && stage_valid[2]) begin
            if (sb_q.size() == 0) begin
                checkOutput("sb_unexpected_word", 32'(stage_data[23:16]), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                checkOutput("sb_data", 32'(stage_data[23:16]), 32'(e.data));
                checkOutput("sb_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic v);
        exp_t e;
        in_data  = d;
        in_valid = v;
        if (sb_en && v) begin
            e.data = d;
            e.cyc  = cyc + STAGES;
            sb_q.push_back(e);
        end
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        sb_en    = 1'b0;
        rst      = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        stall    = '0;
        flush    = '0;
        except   = '0;

        #12;
        checkOutput("reset_data", 32'(stage_data), 32'h0);
        checkOutput("reset_valid", 32'(stage_valid), 32'h0);
        checkOutput("reset_bub", 32'(bub_cnt), 32'h0);
        checkOutput("reset_err", 32'(stall_err), 32'h0);
        rst = 1'b1;

        // Flow-through: three consecutive words reach stage 2 on cycles 3, 4, 5.
        sb_en = 1'b1;
        applyStimulus(8'hA1, 1'b1);
        applyStimulus(8'hB2, 1'b1);
        applyStimulus(8'hC3, 1'b1);
        in_data  = '0;
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (sb_q.size() != 0) step();
        end
        checkOutput("sb_drained", 32'(sb_q.size()), 32'h0);
        sb_en = 1'b0;
        step();

        // Stall bubble: stage 0 holds 55, stage 1 sees a bubble, then 55 exactly once.
        applyStimulus(8'h55, 1'b1);
        in_valid = 1'b0;
        in_data  = '0;
        stall    = 3'b001;
        step();
        checkOutput("bub_s0_data", 32'(stage_data[7:0]), 32'h55);
        checkOutput("bub_s0_valid", 32'(stage_valid[0]), 32'h1);
        checkOutput("bub_s1_data", 32'(stage_data[15:8]), 32'h0);
        checkOutput("bub_s1_valid", 32'(stage_valid[1]), 32'h0);
        stall = 3'b000;
        step();
        checkOutput("bub_s1_word", 32'(stage_data[15:8]), 32'h55);
        checkOutput("bub_s1_valid2", 32'(stage_valid[1]), 32'h1);
        checkOutput("bub_s0_empty", 32'(stage_valid[0]), 32'h0);
        step();
        checkOutput("bub_s2_word", 32'(stage_data[23:16]), 32'h55);
        checkOutput("bub_no_dup", 32'(stage_valid[1]), 32'h0);

        // Flush priority over stall on stage 1.
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        in_valid = 1'b0;
        in_data  = '0;
        stall    = 3'b011;
        flush    = 3'b010;
        step();
        checkOutput("flush_s0_data", 32'(stage_data[7:0]), 32'h22);
        checkOutput("flush_s0_valid", 32'(stage_valid[0]), 32'h1);
        checkOutput("flush_s1_data", 32'(stage_data[15:8]), 32'h0);
        checkOutput("flush_s1_valid", 32'(stage_valid[1]), 32'h0);
        checkOutput("flush_no_err", 32'(stall_err), 32'h0);
        stall = 3'b000;
        flush = 3'b111;
        step();
        checkOutput("flush_all", 32'(stage_valid), 32'h0);
        flush = 3'b000;

        // Kill mask is combinational and does not alter the travelling word.
        applyStimulus(8'h3C, 1'b1);
        in_valid = 1'b0;
        in_data  = '0;
        step();
        except = 3'b010;
        #1;
        checkOutput("kill_s1_masked", 32'(stage_data[15:8]), 32'h30);
        checkOutput("kill_s1_valid", 32'(stage_valid[1]), 32'h1);
        step();
        except = 3'b000;
        #1;
        checkOutput("kill_s2_unmasked", 32'(stage_data[23:16]), 32'h3C);
        except = 3'b100;
        #1;
        checkOutput("kill_s2_masked", 32'(stage_data[23:16]), 32'h30);
        except = 3'b000;

        // Non-monotone stall sets the sticky error.
        checkOutput("err_before", 32'(stall_err), 32'h0);
        stall = 3'b100;
        step();
        stall = 3'b000;
        checkOutput("err_set", 32'(stall_err), 32'h1);
        for (int k = 0; k < 100; k++) begin
            step();
            checkOutput("err_sticky", 32'(stall_err), 32'h1);
        end

        // Async reset between edges with all stages valid.
        applyStimulus(8'h71, 1'b1);
        applyStimulus(8'h72, 1'b1);
        applyStimulus(8'h73, 1'b1);
        in_valid = 1'b0;
        in_data  = '0;
        checkOutput("full_valid", 32'(stage_valid), 32'h7);
        checkOutput("full_data", 32'(stage_data), 32'h717273);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_data", 32'(stage_data), 32'h0);
        checkOutput("async_valid", 32'(stage_valid), 32'h0);
        checkOutput("async_bub", 32'(bub_cnt), 32'h0);
        checkOutput("async_err", 32'(stall_err), 32'h0);
        rst = 1'b1;

        // From reset with idle input every edge retires a bubble.
        step();
        checkOutput("bub_first", 32'(bub_cnt), 32'h1);
        for (int k = 1; k < 16'hFFFE; k++) begin
            step();
        end
        checkOutput("bub_fffe", 32'(bub_cnt), 32'hFFFE);
        step();
        checkOutput("bub_ffff", 32'(bub_cnt), 32'hFFFF);
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput("bub_saturate", 32'(bub_cnt), 32'hFFFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
